// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a bit-timing FSM; define UART_TX_PARITY_EN for 8E1.
// Latency: push at edge N, pop at N+1, start bit on uart_tx from edge N+2; backpressure via tx_ready (FIFO not full).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       uart_tx
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              uart_tx_q, uart_tx_d;
    logic              tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [7:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;

    logic              empty;
    logic              push;
    logic              pop;
    logic              bit_end;

    assign empty   = (count_q == '0);
    assign push    = tx_valid && !full_q;
    assign bit_end = (baud_q == BAUD_LAST);
    // A new byte is taken from idle, or straight from the last stop cycle so frames abut.
    assign pop     = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end));

    assign tx_ready = !full_q;
    assign tx_busy  = (state_q != S_IDLE) || (count_q != '0);
    assign tx_done  = tx_done_q;
    assign uart_tx  = uart_tx_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = tx_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == DEPTH_C);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!empty) state_d = S_START;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            S_STOP:  if (bit_end) state_d = empty ? S_IDLE : S_START;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        baud_d    = (state_q == S_IDLE || bit_end) ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        if (state_q != S_DATA) begin
            bit_idx_d = '0;
        end else if (bit_end) begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
        end
        if (pop) begin
            shift_d = mem_q[rd_ptr_q];
        end
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        parity_d = parity_q;
        if (pop) begin
            parity_d = ^mem_q[rd_ptr_q];
        end
    end
`endif

    // Line level follows the current state through a flop, so tx_done is registered alongside it.
    always_comb begin
        uart_tx_d = 1'b1;
        tx_done_d = 1'b0;
        case (state_q)
            S_START:  uart_tx_d = 1'b0;
            S_DATA:   uart_tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: uart_tx_d = parity_q;
`endif
            S_STOP: begin
                uart_tx_d = 1'b1;
                tx_done_d = bit_end;
            end
            default:  uart_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            uart_tx_q <= 1'b1;
            tx_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            uart_tx_q <= uart_tx_d;
            tx_done_q <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: fast instance (4 clocks/bit) for framing and FIFO behaviour,
// default-rate instance for bit timing at 9600 baud.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int CPB      = 4;
    localparam int SLOW_CPB = 10417;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, tx_done, uart_tx;
    logic [7:0] slow_data = 8'h00;
    logic       slow_valid = 1'b0;
    logic       slow_ready, slow_busy, slow_done, slow_tx;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_busy(tx_busy), .tx_done(tx_done), .uart_tx(uart_tx)
    );

    uart_tx_fifo dut_slow (
        .clk(clk), .reset(reset), .tx_data(slow_data), .tx_valid(slow_valid),
        .tx_ready(slow_ready), .tx_busy(slow_busy), .tx_done(slow_done), .uart_tx(slow_tx)
    );

    // Bit i of the result is the i-th line bit of the frame (start first).
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic check_frame(input logic [10:0] bits, input bit contig, input string nm);
        bit found;
        int lim;
        found = 1'b0;
        lim = contig ? 1 : 300;
        for (int k = 0; k < lim && !found; k++) begin
            @(posedge clk); #1;
            if (uart_tx === 1'b0) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL %s start: uart_tx=%b, want start bit 0", nm, uart_tx);
            return;
        end
        for (int i = 0; i < NB * CPB; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            vectors++;
            if ({uart_tx, tx_done} !== {bits[i / CPB], (i == NB * CPB - 1)}) begin
                miscompares++;
                $display("FAIL %s cycle %0d: {uart_tx,tx_done}=%b%b, want %b%b", nm, i + 1,
                         uart_tx, tx_done, bits[i / CPB], (i == NB * CPB - 1));
            end
        end
    endtask

    task automatic push_byte(input logic [7:0] b, input string nm);
        int k;
        k = 0;
        tx_data = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s push: tx_ready=%b, want 1 within 100 cycles", nm, tx_ready);
        end
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if ({uart_tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset: {uart_tx,tx_ready,tx_busy,tx_done}=%b%b%b%b, want 1100",
                     uart_tx, tx_ready, tx_busy, tx_done);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        logic [10:0] exp_a5;
`ifdef UART_TX_PARITY_EN
        exp_a5 = 11'b10101001010;
`else
        exp_a5 = 11'b01101001010;
`endif
        push_byte(8'hA5, "single");
        vectors++;
        if ({uart_tx, tx_busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL single accept: {uart_tx,tx_busy}=%b%b, want 11", uart_tx, tx_busy);
        end
        @(posedge clk); #1;
        vectors++;
        if (uart_tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single latency: uart_tx=%b one cycle after accept, want 1", uart_tx);
        end
        check_frame(exp_a5, 1'b1, "single_a5");
        @(posedge clk); #1;
        vectors++;
        if ({uart_tx, tx_busy, tx_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL single after: {uart_tx,tx_busy,tx_done}=%b%b%b, want 100",
                     uart_tx, tx_busy, tx_done);
        end
    endtask

    task automatic test_full_back_to_back;
        int idle_bad;
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    tx_data = 8'(i);
                    tx_valid = 1'b1;
                    vectors++;
                    if (tx_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL fill ready before byte %0d: tx_ready=%b, want 1", i, tx_ready);
                    end
                    @(posedge clk); #1;
                end
                tx_data = 8'h06;
                for (int i = 0; i < 3; i++) begin
                    vectors++;
                    if (tx_ready !== 1'b0) begin
                        miscompares++;
                        $display("FAIL full ready: tx_ready=%b with 4 queued, want 0", tx_ready);
                    end
                    @(posedge clk); #1;
                end
                tx_valid = 1'b0;
            end
            begin
                check_frame(frame_bits(8'h01), 1'b0, "b2b_01");
                vectors++;
                if (tx_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL slot freed: tx_ready=%b after pop, want 1", tx_ready);
                end
                check_frame(frame_bits(8'h02), 1'b1, "b2b_02");
                check_frame(frame_bits(8'h03), 1'b1, "b2b_03");
                check_frame(frame_bits(8'h04), 1'b1, "b2b_04");
                check_frame(frame_bits(8'h05), 1'b1, "b2b_05");
            end
        join
        idle_bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if ({uart_tx, tx_busy, tx_done} !== 3'b100) idle_bad++;
        end
        vectors++;
        if (idle_bad != 0) begin
            miscompares++;
            $display("FAIL rejected 0x06: %0d non-idle cycles after 5 frames, want 0", idle_bad);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] wb [8];
        wb = '{8'h3C, 8'hC3, 8'h81, 8'h7E, 8'h55, 8'hAA, 8'h0F, 8'hF0};
        fork
            begin
                for (int i = 0; i < 8; i++) push_byte(wb[i], "wrap");
            end
            begin
                for (int i = 0; i < 8; i++) check_frame(frame_bits(wb[i]), (i != 0), $sformatf("wrap_%0d", i));
            end
        join
        @(posedge clk); #1;
        vectors++;
        if ({uart_tx, tx_busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL wrap drain: {uart_tx,tx_busy}=%b%b, want 10", uart_tx, tx_busy);
        end
    endtask

    task automatic test_reset_mid;
        bit found;
        int bad;
        push_byte(8'h00, "mid");
        push_byte(8'h11, "mid");
        push_byte(8'h22, "mid");
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            if (uart_tx === 1'b0) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (uart_tx !== 1'b0) begin
            miscompares++;
            $display("FAIL mid data bit: uart_tx=%b, want 0", uart_tx);
        end
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if ({uart_tx, tx_ready, tx_busy, tx_done} !== 4'b1100) begin
            miscompares++;
            $display("FAIL async reset: {uart_tx,tx_ready,tx_busy,tx_done}=%b%b%b%b, want 1100",
                     uart_tx, tx_ready, tx_busy, tx_done);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if ({uart_tx, tx_busy, tx_done} !== 3'b100) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL reset discard: %0d non-idle cycles after reset, want 0", bad);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        push_byte(8'h07, "par07");
        check_frame(11'b11000001110, 1'b0, "parity_07");
        push_byte(8'h03, "par03");
        check_frame(11'b10000000110, 1'b0, "parity_03");
    endtask
`endif

    task automatic test_default_timing;
        bit found;
        logic prev;
        logic [4:0] rx;
        int rise_at, fall_at;
        slow_data = 8'h5A;
        slow_valid = 1'b1;
        @(posedge clk); #1;
        slow_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(posedge clk); #1;
            if (slow_tx === 1'b0) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL slow start: slow uart_tx=%b, want 0 within 10 cycles", slow_tx);
            return;
        end
        rx = '1;
        rise_at = 0;
        fall_at = 0;
        prev = slow_tx;
        for (int c = 1; c <= 5209 + 4 * SLOW_CPB; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (prev === 1'b0 && slow_tx === 1'b1 && rise_at == 0) rise_at = c;
            if (prev === 1'b1 && slow_tx === 1'b0 && rise_at != 0 && fall_at == 0) fall_at = c;
            if (c >= 5209 && ((c - 5209) % SLOW_CPB) == 0) rx[(c - 5209) / SLOW_CPB] = slow_tx;
            prev = slow_tx;
        end
        vectors++;
        if (rise_at != 2 * SLOW_CPB + 1) begin
            miscompares++;
            $display("FAIL slow start+d0 length: rise at cycle %0d, want %0d", rise_at, 2 * SLOW_CPB + 1);
        end
        vectors++;
        if (fall_at != 3 * SLOW_CPB + 1) begin
            miscompares++;
            $display("FAIL slow d1 length: fall at cycle %0d, want %0d", fall_at, 3 * SLOW_CPB + 1);
        end
        vectors++;
        if (rx !== 5'b10100) begin
            miscompares++;
            $display("FAIL slow mid-bit samples {d3..d0,start}: %b, want 10100", rx);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_full_back_to_back();
        test_wrap();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_default_timing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter for the pipeline CPU's serial port, the send side of the link whose receive side samples `uart_rx`. The CPU peripheral bus pushes bytes into a small FIFO. A bit-timing state machine serialises them onto `uart_tx` as 8N1 frames (start, 8 data bits LSB first, stop) at 9600 baud from the 100 MHz core clock. It drives the top-level `uart_tx` pin directly.

## Interface
- `CLKS_PER_BIT`, 10417, core clock cycles per serial bit (100 MHz / 9600); legal range ≥ 2.
- `FIFO_DEPTH`, 4, byte entries in the transmit FIFO; power of two, ≥ 2.
- `clk`  input  1  core clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `tx_data`  input  8  byte to transmit; sampled when `tx_valid && tx_ready`.
- `tx_valid`  input  1  request to push `tx_data` into the FIFO.
- `tx_ready`  output  1  FIFO not full; combinational from the registered full flag.
- `tx_busy`  output  1  high while a frame is on the line or the FIFO is non-empty.
- `tx_done`  output  1  one-cycle pulse on the last cycle of each stop bit.
- `uart_tx`  output  1  serial line, registered, idles high.

## Operation
- **Reset values** (asynchronous on `reset`=0): `uart_tx`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0. FIFO pointers and count are 0, FSM is IDLE, and the baud and bit counters are 0.
- **Push:** a byte is written when `tx_valid && tx_ready` at a rising edge. With `tx_ready`=0, `tx_valid` is ignored and the data is dropped; the requester must hold it.
- **FIFO:** circular buffer with read/write pointers of width log2(FIFO_DEPTH) that wrap modulo depth, plus a count of width log2(FIFO_DEPTH)+1.
  - Full when count == FIFO_DEPTH; empty when count == 0.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, no push occurs, even in a cycle where a pop happens.
- **FSM states:**
  - IDLE: `uart_tx`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: drive 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: drive shift[0] for CLKS_PER_BIT cycles, then shift right. After bit index 7, go to PARITY if `UART_TX_PARITY_EN` is defined, otherwise go to STOP.
  - PARITY: drive the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles, and pulse `tx_done` on the final cycle. If the FIFO is non-empty on that cycle, pop and go directly to START (back-to-back, no idle gap); otherwise go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1 and clears on every state or bit change. Each bit lasts exactly CLKS_PER_BIT cycles.
- **`tx_busy`:** (FSM ≠ IDLE) || (count ≠ 0).

## Timing
- **Latency from idle and empty:** bytes accepted at edge N; FIFO non-empty after N; FSM pops at N+1; `uart_tx` falls at edge N+2.
- **Frame length:** 10×CLKS_PER_BIT cycles, or 11×CLKS_PER_BIT with parity.
- **Back-to-back frames:** the next start bit's first cycle immediately follows the stop bit's last cycle.
- **Freeing a slot:** a pop frees a slot, and `tx_ready` rises the cycle after the pop edge.
- **Reset mid-frame:** `uart_tx` goes to 1 immediately (asynchronously). The partial frame and FIFO contents are discarded, and no `tx_done` is produced.
- `uart_tx` is a flop output only, glitch-free.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - An even-parity bit is inserted between data bit 7 and the stop bit.
  - Frame is 8E1, 11 bits.
- `UART_TX_PARITY_EN` not defined:
  - The PARITY state is not compiled.
  - Frame is 8N1, 10 bits.

## Test plan
- **Reset:** hold `reset`=0 for 5 cycles → `uart_tx`=1, `tx_ready`=1, `tx_busy`=0. Assert `reset`=0 mid-data-bit → `uart_tx`=1 within the same cycle, FIFO empty afterwards.
- **Single byte:** CLKS_PER_BIT=4, push 0xA5 →
  - `uart_tx` falls 2 cycles after acceptance.
  - Bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - `tx_done` pulses once on cycle 40 of the frame.
- **Full FIFO and back-to-back:** CLKS_PER_BIT=4, push 0x01..0x05 on consecutive cycles →
  - The first byte enters the FSM and 4 fill the FIFO; `tx_ready` is 0 only when 4 bytes are queued.
  - Then push 0x06 with `tx_ready`=0 → it is not accepted.
  - All 5 frames go out contiguously: 200 cycles, no idle gap, 5 `tx_done` pulses.
- **Push and pop in the same cycle:** count is unchanged and byte order is preserved across pointer wrap (push 8 bytes in total, check 8 frames in push order).
- **Parity (`UART_TX_PARITY_EN`):** send 0x07 → parity bit 1, 11-bit frame; send 0x03 → parity bit 0.
- **Default timing:** CLKS_PER_BIT=10417, send 0x5A → each bit is exactly 10417 cycles; a receiver model sampling at mid-bit recovers 0x5A.
